dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the core load/store unit (port 0) and a debug/DMA master (port 1). It grants at most one access per cycle using round-robin with an optional lock for port-1 bursts, screens each request for alignment and range errors, drives the memory's write-enable/address/write-data, and returns registered read data with a one-cycle response pulse. Sits directly between the requesters and the data memory.

## Interface
- DATA_W, 32: data width.
- ADDR_W, 32: byte-address width.
- DEPTH_WORDS, 256: memory depth in words; word index is addr[ADDR_W-1:2].
- clk  in  1  clock; single clock domain; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pN_req_valid  in  1  port N (N=0,1) request present.
- pN_req_ready  out  1  port N request accepted this cycle.
- pN_req_we  in  1  1 = write, 0 = read.
- pN_req_addr  in  ADDR_W  byte address.
- pN_req_wdata  in  DATA_W  write data.
- p1_req_lock  in  1  port 1 holds the grant after its current accept.
- pN_resp_valid  out  1  one-cycle response pulse for port N.
- pN_resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- pN_resp_err  out  1  valid with pN_resp_valid: misaligned or out-of-range.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data, combinational from mem_addr.

## Operation
- State: last_grant (1 bit), locked (1 bit), per-port response registers.
- Arbitration (combinational, each cycle):
  - locked=1: only port 1 may be granted; port 0 ready=0.
  - Only one port valid: that port is granted.
  - Both valid, unlocked: grant the port != last_grant.
  - pN_req_ready = grant to N; at most one ready per cycle.
- Accept = pN_req_valid && pN_req_ready. On accept, last_grant <= N.
- Lock: on port-1 accept, locked <= p1_req_lock. Lock clears on a port-1 accept with p1_req_lock=0, or on any cycle with locked=1 and p1_req_valid=0.
- Error check on the granted request: err = (addr[1:0] != 0) or (addr[ADDR_W-1:2] >= DEPTH_WORDS).
- Memory drive: mem_addr/mem_wd = granted port's addr/wdata (port 0's when idle); mem_we = accept && we && !err. Errored writes never reach memory.
- Response, registered on the accept edge, pulsed the next cycle:
  - pN_resp_valid = 1 for every accepted read or write.
  - pN_resp_rdata = mem_rd for error-free reads, else 0.
  - pN_resp_err = err.
- No response backpressure; requesters must absorb pulses. Back-to-back accepts from one port give back-to-back responses.

## Timing
- Reset values: all pN_req_ready=0 while in reset; pN_resp_valid=0, pN_resp_rdata=0, pN_resp_err=0; mem_we=0; last_grant=1 so port 0 wins the first contention; locked=0.
- Ready is combinational from valid/state; no valid-to-ready register stage.
- Read latency: accept at edge k -> resp_valid high in cycle k+1 for exactly one cycle with data as of edge k.
- Write is committed by memory at the accept edge; ack pulse at k+1.
- Throughput: one access per cycle total; under sustained contention, grants alternate 0,1,0,1.
- Reset asserted mid-operation: response pulses cleared immediately; in-flight responses are dropped; lock and round-robin state revert to reset values.
- Simultaneous lock request and port-0 request: port 1 keeps the grant for every cycle it stays valid with lock=1; port 0 waits.

## Test plan
- Reset then single read: preload word 5 = 0xDEADBEEF; p0 reads addr 0x14 -> p0_req_ready=1 same cycle, p0_resp_valid pulse next cycle, rdata 0xDEADBEEF, err=0.
- Contention: both ports issue reads continuously for 6 cycles -> grants 0,1,0,1,0,1; each port sees 3 response pulses with correct data.
- Write then read: p1 writes 0x12345678 to 0x20, then p0 reads 0x20 -> mem_we high for exactly one cycle; read returns 0x12345678.
- Errors: p0 writes to 0x22 (misaligned), p1 reads 0x400 (word 256, out of range) -> mem_we stays 0; resp_err=1, rdata=0; memory unchanged.
- Lock burst: p1 issues 4 reads with lock=1 on the first three while p0 is valid throughout -> p0_req_ready=0 for those 4 cycles; p0 is granted in the cycle after the 4th p1 accept.
- Reset mid-burst: assert rst_n=0 while locked with a response pending -> resp_valid drops asynchronously, lock clears; after release, p0 wins the first contention.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the core LSU
// (port 0) and a debug/DMA master (port 1). Round-robin arbitration with a
// port-1 burst lock, alignment/range screening, and registered one-cycle
// response pulses carrying read data.
module dmem_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,

  // port 0: core load/store unit
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_resp_rdata,
  output logic              p0_resp_err,

  // port 1: debug / DMA master
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  input  logic              p1_req_lock,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_resp_rdata,
  output logic              p1_resp_err,

  // data memory
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  // Word-index limit, sized to the word-index field so the range compare
  // is width-matched.
  localparam logic [ADDR_W-3:0] DEPTH_LIMIT = (ADDR_W-2)'(DEPTH_WORDS);

  // ARB_LOCKED means port 1 owns the memory until it drops valid or
  // deasserts lock on an accepted request.
  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  arb_state_t        state;
  arb_state_t        state_next;
  logic              last_grant;

  logic              grant0;
  logic              grant1;
  logic              accept0;
  logic              accept1;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_misaligned;
  logic              sel_out_of_range;
  logic              sel_err;
  logic              sel_read_ok;
  logic [DATA_W-1:0] resp_data_next;

  // Lock state register; reset always releases any port-1 lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_OPEN;
    end else begin
      state <= state_next;
    end
  end

  // Lock transitions: enter on a locked port-1 accept, leave when port 1
  // accepts without lock or stops requesting.
  always_comb begin
    state_next = state;
    case (state)
      ARB_OPEN: begin
        if (accept1 && p1_req_lock) begin
          state_next = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (!p1_req_valid) begin
          state_next = ARB_OPEN;
        end else if (accept1 && !p1_req_lock) begin
          state_next = ARB_OPEN;
        end
      end
      default: begin
        state_next = ARB_OPEN;
      end
    endcase
  end

  // Grant decode: locked gives port 1 exclusive access; otherwise a lone
  // requester wins and contention goes to the port not granted last.
  // Nothing is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      case (state)
        ARB_LOCKED: begin
          grant1 = p1_req_valid;
        end
        default: begin
          if (p0_req_valid && p1_req_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
          end else begin
            grant0 = p0_req_valid;
            grant1 = p1_req_valid;
          end
        end
      endcase
    end
  end

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign accept0      = p0_req_valid && grant0;
  assign accept1      = p1_req_valid && grant1;

  // Round-robin pointer remembers the most recently accepted port; the
  // reset value of 1 lets port 0 win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept0) begin
      last_grant <= 1'b0;
    end else if (accept1) begin
      last_grant <= 1'b1;
    end
  end

  // Request select: the granted port drives the memory, port 0 when idle.
  always_comb begin
    if (grant1) begin
      sel_we    = p1_req_we;
      sel_addr  = p1_req_addr;
      sel_wdata = p1_req_wdata;
    end else begin
      sel_we    = p0_req_we;
      sel_addr  = p0_req_addr;
      sel_wdata = p0_req_wdata;
    end
  end

  // Screening of the selected request: word alignment and word-index range.
  always_comb begin
    sel_misaligned   = (sel_addr[1:0] != 2'b00);
    sel_out_of_range = (sel_addr[ADDR_W-1:2] >= DEPTH_LIMIT);
    sel_err          = sel_misaligned || sel_out_of_range;
    sel_read_ok      = !sel_we && !sel_err;
    resp_data_next   = sel_read_ok ? mem_rd : '0;
  end

  // Errored writes are suppressed here so they never touch memory.
  assign mem_addr = sel_addr;
  assign mem_wd   = sel_wdata;
  assign mem_we   = (accept0 || accept1) && sel_we && !sel_err;

  // Port-0 response register: captured on the accept edge, so it pulses
  // for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_resp_valid <= 1'b0;
      p0_resp_rdata <= '0;
      p0_resp_err   <= 1'b0;
    end else begin
      p0_resp_valid <= accept0;
      p0_resp_rdata <= accept0 ? resp_data_next : '0;
      p0_resp_err   <= accept0 && sel_err;
    end
  end

  // Port-1 response register, same timing as port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_resp_valid <= 1'b0;
      p1_resp_rdata <= '0;
      p1_resp_err   <= 1'b0;
    end else begin
      p1_resp_valid <= accept1;
      p1_resp_rdata <= accept1 ? resp_data_next : '0;
      p1_resp_err   <= accept1 && sel_err;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// behavioural model of grants, lock, screening and a reference memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p0_resp_valid, p0_resp_err;
  logic [31:0] p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_lock;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic        p1_resp_valid, p1_resp_err;
  logic [31:0] p1_resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] tb_mem [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  logic [31:0] ref_mem [256];
  int          m_last;
  bit          m_locked;
  int          exp_port;
  logic [31:0] exp_rd;
  bit          exp_err;

  int passed;
  int failed;
  int total;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_lock(p1_req_lock),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory under the DUT: preload port during reset, DUT writes afterwards.
  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_idx] <= pre_data;
    else if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wd;
  end

  assign mem_rd = (mem_addr[31:10] == 22'd0) ? tb_mem[mem_addr[9:2]] : 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit addrErr(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= 256);
  endfunction

  // Winner according to the arbitration rules; -1 when nobody is granted.
  function automatic int modelGrant(input bit v0, input bit v1);
    if (m_locked) return v1 ? 1 : -1;
    if (v0 && v1) return 1 - m_last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic checkResponses();
    checkOutput("p0_resp_valid", 32'(p0_resp_valid), 32'(exp_port == 0));
    checkOutput("p1_resp_valid", 32'(p1_resp_valid), 32'(exp_port == 1));
    if (exp_port == 0) begin
      checkOutput("p0_resp_rdata", p0_resp_rdata, exp_rd);
      checkOutput("p0_resp_err", 32'(p0_resp_err), 32'(exp_err));
    end
    if (exp_port == 1) begin
      checkOutput("p1_resp_rdata", p1_resp_rdata, exp_rd);
      checkOutput("p1_resp_err", 32'(p1_resp_err), 32'(exp_err));
    end
  endtask

  // One clock cycle: drive both ports, check outputs, advance the model.
  task automatic applyStimulus(input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                               input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                               input bit lk);
    int          g;
    bit          gw;
    bit          ge;
    logic [31:0] ga;
    logic [31:0] gd;
    @(negedge clk);
    p0_req_valid = v0; p0_req_we = w0; p0_req_addr = a0; p0_req_wdata = d0;
    p1_req_valid = v1; p1_req_we = w1; p1_req_addr = a1; p1_req_wdata = d1;
    p1_req_lock  = lk;
    #1;
    checkResponses();
    g  = modelGrant(v0, v1);
    ga = (g == 1) ? a1 : a0;
    gd = (g == 1) ? d1 : d0;
    gw = (g == 1) ? w1 : w0;
    ge = addrErr(ga);
    checkOutput("p0_req_ready", 32'(p0_req_ready), 32'(g == 0));
    checkOutput("p1_req_ready", 32'(p1_req_ready), 32'(g == 1));
    checkOutput("mem_addr", mem_addr, ga);
    checkOutput("mem_wd", mem_wd, gd);
    checkOutput("mem_we", 32'(mem_we), 32'(g >= 0 && gw && !ge));
    exp_port = g;
    exp_err  = (g >= 0) && ge;
    exp_rd   = (g >= 0 && !gw && !ge) ? ref_mem[ga / 4] : 32'd0;
    if (g >= 0 && gw && !ge) ref_mem[ga / 4] = gd;
    if (g >= 0) m_last = g;
    if (g == 1) m_locked = lk;
    else if (m_locked && !v1) m_locked = 0;
    @(posedge clk);
  endtask

  function automatic logic [31:0] randAddr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 32'($urandom_range(0, 15)) * 4;
    if (r == 7) return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
    if (r == 8) return 32'($urandom_range(256, 400)) * 4;
    return $urandom;
  endfunction

  task automatic idleStep();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst_n = 1'b0;
    pre_we = 1'b0; pre_idx = 8'd0; pre_data = 32'd0;
    p0_req_valid = 0; p0_req_we = 0; p0_req_addr = 0; p0_req_wdata = 0;
    p1_req_valid = 0; p1_req_we = 0; p1_req_addr = 0; p1_req_wdata = 0; p1_req_lock = 0;
    m_last = 1; m_locked = 0; exp_port = -1; exp_rd = 0; exp_err = 0;

    // Preload memory under reset; word 5 carries the known pattern.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = 8'(i);
      pre_data = (i == 5) ? 32'hDEADBEEF : (32'(i) * 32'h01010101) ^ 32'hA5A50000;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;

    // Reset state with both ports requesting.
    p0_req_valid = 1; p0_req_addr = 32'h14;
    p1_req_valid = 1; p1_req_addr = 32'h18;
    #1;
    $display("[TB] checking reset state");
    checkOutput("reset_p0_ready", 32'(p0_req_ready), 32'd0);
    checkOutput("reset_p1_ready", 32'(p1_req_ready), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_p0_resp_valid", 32'(p0_resp_valid), 32'd0);
    checkOutput("reset_p1_resp_valid", 32'(p1_resp_valid), 32'd0);
    checkOutput("reset_p0_rdata", p0_resp_rdata, 32'd0);
    checkOutput("reset_p1_err", 32'(p1_resp_err), 32'd0);
    p0_req_valid = 0; p1_req_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single read");
    applyStimulus(1, 0, 32'h14, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h14, 0, 0);

    $display("[TB] contention");
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 32'h14, 0, 1, 0, 32'h18, 0, 0);

    $display("[TB] write then read");
    applyStimulus(0, 0, 32'h0, 0, 1, 1, 32'h20, 32'h12345678, 0);
    applyStimulus(1, 0, 32'h20, 0, 0, 0, 32'h0, 0, 0);

    $display("[TB] error screening");
    applyStimulus(1, 1, 32'h22, 32'hBAD0BAD0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h400, 0, 0);
    applyStimulus(1, 0, 32'h20, 0, 0, 0, 32'h0, 0, 0);

    $display("[TB] lock burst");
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h30, 0, 1);
    applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h34, 0, 1);
    applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h38, 0, 1);
    applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h3C, 0, 0);
    applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h40, 0, 0);
    idleStep();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randAddr(), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randAddr(), $urandom,
                    1'($urandom_range(0, 1)));
    end
    idleStep();

    $display("[TB] reset mid-burst");
    applyStimulus(1, 0, 32'h8, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 1);
    #2;
    checkOutput("pending_p1_resp_valid", 32'(p1_resp_valid), 32'(exp_port == 1));
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_p1_resp_valid", 32'(p1_resp_valid), 32'd0);
    checkOutput("midreset_p1_rdata", p1_resp_rdata, 32'd0);
    checkOutput("midreset_p0_ready", 32'(p0_req_ready), 32'd0);
    checkOutput("midreset_p1_ready", 32'(p1_req_ready), 32'd0);
    m_last = 1; m_locked = 0; exp_port = -1; exp_rd = 0; exp_err = 0;
    p0_req_valid = 0; p1_req_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 1);
    idleStep();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
